// File: rtl/stack_unit.sv
// stack_unit: hardware call/data stack engine.
// Pushes and pops 16-bit register values, 4-bit flag sets and 32-bit PCs
// (two words, high word at the higher address) to a word-addressed data
// memory. SP points at the next free word, and the stack grows downward from
// SP_INIT toward SP_MIN. A push or pop that would leave that region is
// rejected through the ERR state without touching memory or SP.
module stack_unit #(
   parameter int              AW      = 12,
   parameter logic [AW-1:0]   SP_INIT = 12'hFFF,
   parameter logic [AW-1:0]   SP_MIN  = 12'h800
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_valid,
   input  logic [2:0]      cmd_op,
   output logic            cmd_ready,
   input  logic [15:0]     reg_in,
   input  logic [31:0]     pc_in,
   input  logic [3:0]      flags_in,
   output logic [AW-1:0]   mem_addr,
   output logic [15:0]     mem_wdata,
   output logic            mem_we,
   output logic            mem_re,
   input  logic [15:0]     mem_rdata,
   output logic [15:0]     reg_wdata,
   output logic            reg_wvalid,
   output logic [31:0]     pc_out,
   output logic            pc_load,
   output logic [3:0]      flags_out,
   output logic            flags_load,
   output logic            overflow,
   output logic            underflow,
   output logic [AW-1:0]   sp
);

   localparam logic [2:0] OP_PUSH_REG   = 3'b000;
   localparam logic [2:0] OP_POP_REG    = 3'b001;
   localparam logic [2:0] OP_PUSH_PC    = 3'b010;
   localparam logic [2:0] OP_POP_PC     = 3'b011;
   localparam logic [2:0] OP_PUSH_FLAGS = 3'b100;
   localparam logic [2:0] OP_POP_FLAGS  = 3'b101;

   localparam logic [AW-1:0] ONE_W = AW'(1);
   localparam logic [AW-1:0] TWO_W = AW'(2);
   localparam logic [AW:0]   ONE_X = (AW+1)'(1);
   localparam logic [AW:0]   TWO_X = (AW+1)'(2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_HI,
      S_WR_LO,
      S_RD_1,
      S_RD_2,
      S_RD_DONE,
      S_ERR
   } state_t;

   state_t         state_q, state_d;
   logic [2:0]     op_q, op_d;            // opcode latched at acceptance
   logic [31:0]    opnd_q, opnd_d;        // push operand, zero-extended
   logic [15:0]    low_q, low_d;          // low PC word captured during RD_2
   logic [AW-1:0]  sp_q, sp_d;
   logic [15:0]    reg_hold_q, reg_hold_d;
   logic [31:0]    pc_hold_q, pc_hold_d;
   logic [3:0]     flags_hold_q, flags_hold_d;
   logic           ovf_q, ovf_d;          // 1: ERR reports overflow, 0: underflow

   logic           cmd_is_pc;
   logic           op_is_pc;
   logic [AW:0]    cmd_n_x;
   logic [AW-1:0]  op_n_w;
   logic           push_ovf;
   logic           pop_unf;

   // Word count of the command being offered and of the one in flight.
   assign cmd_is_pc = (cmd_op == OP_PUSH_PC) || (cmd_op == OP_POP_PC);
   assign cmd_n_x   = cmd_is_pc ? TWO_X : ONE_X;
   assign op_is_pc  = (op_q == OP_PUSH_PC) || (op_q == OP_POP_PC);
   assign op_n_w    = op_is_pc ? TWO_W : ONE_W;

   // Range checks are done one bit wider than SP so that neither side of the
   // comparison can wrap: a push needs SP-n+1 >= SP_MIN, rewritten as
   // SP+1 >= SP_MIN+n; a pop needs SP+n <= SP_INIT.
   assign push_ovf = ({1'b0, sp_q} + ONE_X) < ({1'b0, SP_MIN} + cmd_n_x);
   assign pop_unf  = ({1'b0, sp_q} + cmd_n_x) > {1'b0, SP_INIT};

   assign sp = sp_q;

   // State and datapath registers; reset discards any in-flight command.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         op_q         <= 3'b000;
         opnd_q       <= 32'h0;
         low_q        <= 16'h0;
         sp_q         <= SP_INIT;
         reg_hold_q   <= 16'h0;
         pc_hold_q    <= 32'h0;
         flags_hold_q <= 4'h0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         opnd_q       <= opnd_d;
         low_q        <= low_d;
         sp_q         <= sp_d;
         reg_hold_q   <= reg_hold_d;
         pc_hold_q    <= pc_hold_d;
         flags_hold_q <= flags_hold_d;
         ovf_q        <= ovf_d;
      end
   end

   // Next-state logic and state-decoded outputs; result data is bypassed
   // from mem_rdata during RD_DONE so it lines up with its strobe.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      opnd_d       = opnd_q;
      low_d        = low_q;
      sp_d         = sp_q;
      reg_hold_d   = reg_hold_q;
      pc_hold_d    = pc_hold_q;
      flags_hold_d = flags_hold_q;
      ovf_d        = ovf_q;

      cmd_ready    = 1'b0;
      mem_addr     = '0;
      mem_wdata    = 16'h0;
      mem_we       = 1'b0;
      mem_re       = 1'b0;
      reg_wdata    = reg_hold_q;
      reg_wvalid   = 1'b0;
      pc_out       = pc_hold_q;
      pc_load      = 1'b0;
      flags_out    = flags_hold_q;
      flags_load   = 1'b0;
      overflow     = 1'b0;
      underflow    = 1'b0;

      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               op_d = cmd_op;
               case (cmd_op)
                  OP_PUSH_REG, OP_PUSH_PC, OP_PUSH_FLAGS: begin
                     if (cmd_op == OP_PUSH_PC) begin
                        opnd_d = pc_in;
                     end else if (cmd_op == OP_PUSH_REG) begin
                        opnd_d = {16'h0, reg_in};
                     end else begin
                        opnd_d = {28'h0, flags_in};
                     end
                     if (push_ovf) begin
                        ovf_d   = 1'b1;
                        state_d = S_ERR;
                     end else if (cmd_op == OP_PUSH_PC) begin
                        state_d = S_WR_HI;
                     end else begin
                        state_d = S_WR_LO;
                     end
                  end
                  OP_POP_REG, OP_POP_PC, OP_POP_FLAGS: begin
                     if (pop_unf) begin
                        ovf_d   = 1'b0;
                        state_d = S_ERR;
                     end else begin
                        state_d = S_RD_1;
                     end
                  end
                  default: begin
                     // Reserved opcodes are consumed with no effect.
                     state_d = S_IDLE;
                  end
               endcase
            end
         end

         S_WR_HI: begin
            mem_we    = 1'b1;
            mem_addr  = sp_q;
            mem_wdata = opnd_q[31:16];
            state_d   = S_WR_LO;
         end

         S_WR_LO: begin
            mem_we    = 1'b1;
            mem_addr  = op_is_pc ? (sp_q - ONE_W) : sp_q;
            mem_wdata = opnd_q[15:0];
            sp_d      = sp_q - op_n_w;
            state_d   = S_IDLE;
         end

         S_RD_1: begin
            mem_re   = 1'b1;
            mem_addr = sp_q + ONE_W;
            state_d  = (op_q == OP_POP_PC) ? S_RD_2 : S_RD_DONE;
         end

         S_RD_2: begin
            // The low word requested in RD_1 is on mem_rdata now.
            mem_re   = 1'b1;
            mem_addr = sp_q + TWO_W;
            low_d    = mem_rdata;
            state_d  = S_RD_DONE;
         end

         S_RD_DONE: begin
            sp_d    = sp_q + op_n_w;
            state_d = S_IDLE;
            case (op_q)
               OP_POP_REG: begin
                  reg_wvalid = 1'b1;
                  reg_wdata  = mem_rdata;
                  reg_hold_d = mem_rdata;
               end
               OP_POP_FLAGS: begin
                  flags_load   = 1'b1;
                  flags_out    = mem_rdata[3:0];
                  flags_hold_d = mem_rdata[3:0];
               end
               OP_POP_PC: begin
                  pc_load   = 1'b1;
                  pc_out    = {mem_rdata, low_q};
                  pc_hold_d = {mem_rdata, low_q};
               end
               default: begin
               end
            endcase
         end

         S_ERR: begin
            overflow  = ovf_q;
            underflow = ~ovf_q;
            state_d   = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed, table-driven bench for stack_unit with a simple
// registered-read memory attached to the DUT memory port.
module tb_stack_unit;

   localparam logic [2:0] PUSH_REG   = 3'b000;
   localparam logic [2:0] POP_REG    = 3'b001;
   localparam logic [2:0] PUSH_PC    = 3'b010;
   localparam logic [2:0] POP_PC     = 3'b011;
   localparam logic [2:0] PUSH_FLAGS = 3'b100;
   localparam logic [2:0] POP_FLAGS  = 3'b101;

   // result kinds
   localparam int K_NONE = 0, K_REG = 1, K_PC = 2, K_FLAGS = 3, K_OVF = 4, K_UNF = 5;
   localparam int NV = 23;

   logic          clk;
   logic          reset;
   logic          cmd_valid;
   logic [2:0]    cmd_op;
   logic          cmd_ready;
   logic [15:0]   reg_in;
   logic [31:0]   pc_in;
   logic [3:0]    flags_in;
   logic [11:0]   mem_addr;
   logic [15:0]   mem_wdata;
   logic          mem_we;
   logic          mem_re;
   logic [15:0]   mem_rdata;
   logic [15:0]   reg_wdata;
   logic          reg_wvalid;
   logic [31:0]   pc_out;
   logic          pc_load;
   logic [3:0]    flags_out;
   logic          flags_load;
   logic          overflow;
   logic          underflow;
   logic [11:0]   sp;

   stack_unit dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_op     (cmd_op),
      .cmd_ready  (cmd_ready),
      .reg_in     (reg_in),
      .pc_in      (pc_in),
      .flags_in   (flags_in),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_rdata  (mem_rdata),
      .reg_wdata  (reg_wdata),
      .reg_wvalid (reg_wvalid),
      .pc_out     (pc_out),
      .pc_load    (pc_load),
      .flags_out  (flags_out),
      .flags_load (flags_load),
      .overflow   (overflow),
      .underflow  (underflow),
      .sp         (sp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // data memory: write on we, read data valid the cycle after re
   logic [15:0] tb_mem [0:4095];
   always @(posedge clk) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= tb_mem[mem_addr];
   end

   typedef struct {
      bit          fill;      // push the stack down to 801 before this vector
      logic [2:0]  op;
      logic [31:0] opnd;
      int          nw;
      logic [11:0] wa0;
      logic [15:0] wd0;
      logic [11:0] wa1;
      logic [15:0] wd1;
      int          nr;
      logic [11:0] ra0;
      logic [11:0] ra1;
      int          kind;
      logic [31:0] val;
      int          lat;       // cycle of the last write, strobe or error pulse
      logic [11:0] sp;
   } vec_t;

   vec_t vecs [NV];

   int tests;
   int failures;

   // observations from the last command
   logic        o_ready;
   int          o_done;
   int          o_nw, o_nr, o_kind, o_lat, o_bad;
   logic [11:0] o_wa [2];
   logic [15:0] o_wd [2];
   logic [11:0] o_ra [2];
   logic [31:0] o_val;
   logic [11:0] o_sp;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s [%0d]: got %h, expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic run_cmd(input logic [2:0] op, input logic [31:0] opnd);
      o_nw = 0; o_nr = 0; o_kind = K_NONE; o_lat = 0; o_bad = 0; o_done = 0;
      o_val = 32'h0;
      for (int k = 0; k < 2; k++) begin
         o_wa[k] = 12'h0; o_wd[k] = 16'h0; o_ra[k] = 12'h0;
      end
      @(negedge clk);
      o_ready   = cmd_ready;
      cmd_valid = 1'b1;
      cmd_op    = op;
      reg_in    = opnd[15:0];
      pc_in     = opnd;
      flags_in  = opnd[3:0];
      @(posedge clk);
      #1;
      // scramble operands: the accepted command must not see these
      cmd_valid = 1'b0;
      reg_in    = ~reg_in;
      pc_in     = ~pc_in;
      flags_in  = ~flags_in;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (mem_we && mem_re) o_bad++;
         if ((int'(reg_wvalid) + int'(pc_load) + int'(flags_load)
              + int'(overflow) + int'(underflow)) > 1) o_bad++;
         if (mem_we) begin
            if (o_nw < 2) begin
               o_wa[o_nw] = mem_addr;
               o_wd[o_nw] = mem_wdata;
            end
            o_nw++;
            o_lat = c;
         end
         if (mem_re) begin
            if (o_nr < 2) o_ra[o_nr] = mem_addr;
            o_nr++;
         end
         if (reg_wvalid) begin o_kind = K_REG;   o_val = {16'h0, reg_wdata}; o_lat = c; end
         if (pc_load)    begin o_kind = K_PC;    o_val = pc_out;             o_lat = c; end
         if (flags_load) begin o_kind = K_FLAGS; o_val = {28'h0, flags_out}; o_lat = c; end
         if (overflow)   begin o_kind = K_OVF;   o_lat = c; end
         if (underflow)  begin o_kind = K_UNF;   o_lat = c; end
         if (cmd_ready) begin
            o_done = 1;
            break;
         end
      end
      o_sp = sp;
   endtask

   // Reset the unit 'cyc' cycles after accepting a command, then make sure
   // nothing of that command survives the release.
   task automatic reset_mid(input int idx, input logic [2:0] op, input logic [31:0] opnd,
                            input int cyc, input logic exp_we, input logic [11:0] exp_addr);
      int quiet_bad;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      reg_in    = opnd[15:0];
      pc_in     = opnd;
      flags_in  = opnd[3:0];
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (cyc) @(negedge clk);
      chk("mid_we",   idx, 32'(mem_we), 32'(exp_we));
      chk("mid_re",   idx, 32'(mem_re), 32'(!exp_we));
      chk("mid_addr", idx, 32'(mem_addr), 32'(exp_addr));
      #1 reset = 1'b0;
      #1;
      chk("rst_sp",      idx, 32'(sp), 32'h0FFF);
      chk("rst_we_re",   idx, 32'({mem_we, mem_re}), 32'h0);
      chk("rst_strobes", idx, 32'({pc_load, reg_wvalid, flags_load}), 32'h0);
      chk("rst_addr",    idx, 32'(mem_addr), 32'h0);
      @(negedge clk);
      @(negedge clk);
      #1 reset = 1'b1;
      quiet_bad = 0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) begin
            chk("ready_after_release", idx, 32'(cmd_ready), 32'h1);
            chk("sp_after_release",    idx, 32'(sp), 32'h0FFF);
         end
         if (mem_we || mem_re || pc_load || reg_wvalid || flags_load) quiet_bad++;
      end
      chk("quiet_after_release", idx, quiet_bad, 0);
      $display("[TB] reset-mid op=%0d after %0d cycles, sp=%h", op, cyc, sp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0;
      failures = 0;
      reset = 1'b0;
      cmd_valid = 1'b0;
      cmd_op = 3'b000;
      reg_in = 16'h0;
      pc_in = 32'h0;
      flags_in = 4'h0;

      //            fill op          opnd           nw wa0     wd0      wa1     wd1      nr ra0     ra1     kind     val            lat sp
      vecs[0]  = '{1'b0, PUSH_PC,    32'h12345678, 2, 12'hFFF, 16'h1234, 12'hFFE, 16'h5678, 0, 12'h000, 12'h000, K_NONE,  32'h0,         2, 12'hFFD};
      vecs[1]  = '{1'b0, POP_PC,     32'h0,        0, 12'h000, 16'h0000, 12'h000, 16'h0000, 2, 12'hFFE, 12'hFFF, K_PC,    32'h12345678,  3, 12'hFFF};
      vecs[2]  = '{1'b0, PUSH_FLAGS, 32'hFFFFFFFA, 1, 12'hFFF, 16'h000A, 12'h000, 16'h0000, 0, 12'h000, 12'h000, K_NONE,  32'h0,         1, 12'hFFE};
      vecs[3]  = '{1'b0, POP_FLAGS,  32'h0,        0, 12'h000, 16'h0000, 12'h000, 16'h0000, 1, 12'hFFF, 12'h000, K_FLAGS, 32'hA,         2, 12'hFFF};
      vecs[4]  = '{1'b0, POP_REG,    32'h0,        0, 12'h000, 16'h0000, 12'h000, 16'h0000, 0, 12'h000, 12'h000, K_UNF,   32'h0,         1, 12'hFFF};
      vecs[5]  = '{1'b0, PUSH_REG,   32'h5555CAFE, 1, 12'hFFF, 16'hCAFE, 12'h000, 16'h0000, 0, 12'h000, 12'h000, K_NONE,  32'h0,         1, 12'hFFE};
      vecs[6]  = '{1'b0, 3'b110,     32'hFFFFFFFF, 0, 12'h000, 16'h0000, 12'h000, 16'h0000, 0, 12'h000, 12'h000, K_NONE,  32'h0,         0, 12'hFFE};
      vecs[7]  = '{1'b0, PUSH_REG,   32'h00000102, 1, 12'hFFE, 16'h0102, 12'h000, 16'h0000, 0, 12'h000, 12'h000, K_NONE,  32'h0,         1, 12'hFFD};
      vecs[8]  = '{1'b0, POP_REG,    32'h0,        0, 12'h000, 16'h0000, 12'h000, 16'h0000, 1, 12'hFFE, 12'h000, K_REG,   32'h0102,      2, 12'hFFE};
      vecs[9]  = '{1'b0, POP_REG,    32'h0,        0, 12'h000, 16'h0000, 12'h000, 16'h0000, 1, 12'hFFF, 12'h000, K_REG,   32'hCAFE,      2, 12'hFFF};
      vecs[10] = '{1'b0, POP_PC,     32'h0,        0, 12'h000, 16'h0000, 12'h000, 16'h0000, 0, 12'h000, 12'h000, K_UNF,   32'h0,         1, 12'hFFF};
      vecs[11] = '{1'b0, PUSH_FLAGS, 32'h00000005, 1, 12'hFFF, 16'h0005, 12'h000, 16'h0000, 0, 12'h000, 12'h000, K_NONE,  32'h0,         1, 12'hFFE};
      vecs[12] = '{1'b0, POP_PC,     32'h0,        0, 12'h000, 16'h0000, 12'h000, 16'h0000, 0, 12'h000, 12'h000, K_UNF,   32'h0,         1, 12'hFFE};
      vecs[13] = '{1'b0, POP_FLAGS,  32'h0,        0, 12'h000, 16'h0000, 12'h000, 16'h0000, 1, 12'hFFF, 12'h000, K_FLAGS, 32'h5,         2, 12'hFFF};
      vecs[14] = '{1'b0, 3'b111,     32'h0,        0, 12'h000, 16'h0000, 12'h000, 16'h0000, 0, 12'h000, 12'h000, K_NONE,  32'h0,         0, 12'hFFF};
      vecs[15] = '{1'b1, PUSH_REG,   32'h00001111, 1, 12'h801, 16'h1111, 12'h000, 16'h0000, 0, 12'h000, 12'h000, K_NONE,  32'h0,         1, 12'h800};
      vecs[16] = '{1'b0, PUSH_PC,    32'hDEAD0000, 0, 12'h000, 16'h0000, 12'h000, 16'h0000, 0, 12'h000, 12'h000, K_OVF,   32'h0,         1, 12'h800};
      vecs[17] = '{1'b0, PUSH_REG,   32'h0000BEEF, 1, 12'h800, 16'hBEEF, 12'h000, 16'h0000, 0, 12'h000, 12'h000, K_NONE,  32'h0,         1, 12'h7FF};
      vecs[18] = '{1'b0, PUSH_FLAGS, 32'h00000003, 0, 12'h000, 16'h0000, 12'h000, 16'h0000, 0, 12'h000, 12'h000, K_OVF,   32'h0,         1, 12'h7FF};
      vecs[19] = '{1'b0, POP_REG,    32'h0,        0, 12'h000, 16'h0000, 12'h000, 16'h0000, 1, 12'h800, 12'h000, K_REG,   32'hBEEF,      2, 12'h800};
      vecs[20] = '{1'b0, POP_REG,    32'h0,        0, 12'h000, 16'h0000, 12'h000, 16'h0000, 1, 12'h801, 12'h000, K_REG,   32'h1111,      2, 12'h801};
      vecs[21] = '{1'b0, PUSH_PC,    32'hA5A55A5A, 2, 12'h801, 16'hA5A5, 12'h800, 16'h5A5A, 0, 12'h000, 12'h000, K_NONE,  32'h0,         2, 12'h7FF};
      vecs[22] = '{1'b0, POP_PC,     32'h0,        0, 12'h000, 16'h0000, 12'h000, 16'h0000, 2, 12'h800, 12'h801, K_PC,    32'hA5A55A5A,  3, 12'h801};

      // values while held in reset
      repeat (2) @(negedge clk);
      chk("reset_sp",       200, 32'(sp), 32'h0FFF);
      chk("reset_ready",    200, 32'(cmd_ready), 32'h1);
      chk("reset_we_re",    200, 32'({mem_we, mem_re}), 32'h0);
      chk("reset_addr",     200, 32'(mem_addr), 32'h0);
      chk("reset_wdata",    200, 32'(mem_wdata), 32'h0);
      chk("reset_outs",     200, 32'({reg_wdata, flags_out}), 32'h0);
      chk("reset_pc_out",   200, pc_out, 32'h0);
      chk("reset_strobes",  200, 32'({reg_wvalid, pc_load, flags_load, overflow, underflow}), 32'h0);
      #1 reset = 1'b1;

      for (int i = 0; i < NV; i++) begin
         if (vecs[i].fill) begin
            for (int k = 0; k < 1023; k++) run_cmd(PUSH_PC, {16'(k), 16'h7777});
            chk("fill_sp", i, 32'(o_sp), 32'h0801);
            $display("[TB] fill with 1023 PUSH_PC done, sp=%h", o_sp);
         end
         run_cmd(vecs[i].op, vecs[i].opnd);
         chk("ready",     i, 32'(o_ready), 32'h1);
         chk("completed", i, o_done, 1);
         chk("exclusive", i, o_bad, 0);
         chk("n_writes",  i, o_nw, vecs[i].nw);
         if (vecs[i].nw >= 1) begin
            chk("wr_addr0", i, 32'(o_wa[0]), 32'(vecs[i].wa0));
            chk("wr_data0", i, 32'(o_wd[0]), 32'(vecs[i].wd0));
         end
         if (vecs[i].nw >= 2) begin
            chk("wr_addr1", i, 32'(o_wa[1]), 32'(vecs[i].wa1));
            chk("wr_data1", i, 32'(o_wd[1]), 32'(vecs[i].wd1));
         end
         chk("n_reads", i, o_nr, vecs[i].nr);
         if (vecs[i].nr >= 1) chk("rd_addr0", i, 32'(o_ra[0]), 32'(vecs[i].ra0));
         if (vecs[i].nr >= 2) chk("rd_addr1", i, 32'(o_ra[1]), 32'(vecs[i].ra1));
         chk("result_kind", i, o_kind, vecs[i].kind);
         if (vecs[i].kind >= K_REG && vecs[i].kind <= K_FLAGS)
            chk("result_val", i, o_val, vecs[i].val);
         chk("latency", i, o_lat, vecs[i].lat);
         chk("sp", i, 32'(o_sp), 32'(vecs[i].sp));
         $display("[TB] vec %0d op=%0d writes=%0d reads=%0d kind=%0d val=%h lat=%0d sp=%h",
                  i, vecs[i].op, o_nw, o_nr, o_kind, o_val, o_lat, o_sp);
      end

      // held outputs: last captured values remain between strobes
      @(negedge clk);
      chk("hold_pc",    300, pc_out, 32'hA5A55A5A);
      chk("hold_reg",   300, 32'(reg_wdata), 32'h1111);
      chk("hold_flags", 300, 32'(flags_out), 32'h5);

      // reset in the middle of operations
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      #1 reset = 1'b1;
      run_cmd(PUSH_PC, 32'h12345678);
      chk("pre_mid_sp", 100, 32'(o_sp), 32'h0FFD);
      $display("[TB] push pc 12345678 before reset-mid, sp=%h", o_sp);
      reset_mid(101, POP_PC, 32'h0, 2, 1'b0, 12'hFFF);
      reset_mid(102, PUSH_PC, 32'hCAFEF00D, 1, 1'b1, 12'hFFF);
      run_cmd(POP_REG, 32'h0);
      chk("post_mid_kind", 103, o_kind, K_UNF);
      chk("post_mid_sp",   103, 32'(o_sp), 32'h0FFF);
      $display("[TB] pop reg after reset-mid kind=%0d sp=%h", o_kind, o_sp);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 Parameter AW, default 12: data-memory word-address width.
REQ-002 Parameter SP_INIT, default 12'hFFF: SP reset value and top of stack region.
REQ-003 Parameter SP_MIN, default 12'h800: lowest legal stack address.
REQ-004 clk  in  1: rising-edge clock.
REQ-005 reset  in  1: asynchronous, active-low reset.
REQ-006 cmd_valid  in  1: a stack command is presented.
REQ-007 cmd_op  in  3: 000 PUSH_REG, 001 POP_REG, 010 PUSH_PC, 011 POP_PC, 100 PUSH_FLAGS, 101 POP_FLAGS; 11x reserved.
REQ-008 cmd_ready  out  1: the unit accepts a command this cycle.
REQ-009 reg_in  in  16: register operand for PUSH_REG.
REQ-010 pc_in  in  32: PC operand for PUSH_PC.
REQ-011 flags_in  in  4: flags operand for PUSH_FLAGS.
REQ-012 mem_addr  out  AW: data-memory address.
REQ-013 mem_wdata  out  16: data-memory write data.
REQ-014 mem_we, mem_re  out  1 each: memory write strobe and read strobe. Read data is valid on mem_rdata the cycle after mem_re.
REQ-015 mem_rdata  in  16: memory read data.
REQ-016 reg_wdata  out  16 / reg_wvalid  out  1: popped register value and its 1-cycle strobe.
REQ-017 pc_out  out  32 / pc_load  out  1: popped PC and its 1-cycle load strobe.
REQ-018 flags_out  out  4 / flags_load  out  1: popped flags and their 1-cycle load strobe.
REQ-019 overflow, underflow  out  1 each: 1-cycle error pulses.
REQ-020 sp  out  AW: current stack pointer, pointing to the next free word.

Function
REQ-021 Acceptance: a command is accepted on a clk edge where cmd_valid=1 and cmd_ready=1; cmd_ready=1 only in state IDLE.
REQ-022 Operand latching: the opcode and the operand (reg_in, pc_in or flags_in) are latched at acceptance; later changes to the inputs have no effect.
REQ-023 Word counts: n = 1 for REG and FLAGS commands, n = 2 for PC commands.
REQ-024 States: IDLE, WR_HI, WR_LO, RD_1, RD_2, RD_DONE, ERR.
REQ-025 Overflow check: a push with SP-n+1 < SP_MIN goes to ERR instead of executing.
REQ-026 Underflow check: a pop with SP+n > SP_INIT goes to ERR instead of executing.
REQ-027 ERR behaviour: ERR pulses overflow or underflow for 1 cycle, performs no memory access, leaves SP unchanged and returns to IDLE.
REQ-028 PUSH_REG / PUSH_FLAGS: go to WR_LO, which drives mem_we=1, addr=SP and wdata=operand zero-extended to 16 bits; SP decrements by 1 at exit; then IDLE.
REQ-029 PUSH_PC: WR_HI drives mem_we=1, addr=SP, wdata=pc[31:16]; WR_LO drives addr=SP-1, wdata=pc[15:0]; SP decrements by 2 at WR_LO exit.
REQ-030 POP_REG / POP_FLAGS: RD_1 drives mem_re=1, addr=SP+1; RD_DONE captures mem_rdata and pulses reg_wvalid (reg_wdata=rdata) or flags_load (flags_out=rdata[3:0]); SP increments by 1 at RD_DONE.
REQ-031 POP_PC, read sequence: RD_1 drives mem_re=1, addr=SP+1 (low word); RD_2 drives mem_re=1, addr=SP+2 (high word) and captures the low word.
REQ-032 POP_PC, completion: RD_DONE pulses pc_load with pc_out={rdata, low}; SP increments by 2.
REQ-033 Latency, accept to completion: push 1 cycle (n=1) or 2 cycles (n=2); pop result strobe 2 cycles (n=1) or 3 cycles (n=2) after acceptance.
REQ-034 Address arithmetic: SP arithmetic is modulo 2^AW; the range checks in REQ-025 and REQ-026 guarantee that no in-range operation wraps.
REQ-035 Mutual exclusion: mem_we and mem_re are never both 1; at most one of the pc_load, flags_load and reg_wvalid strobes is 1 in any cycle.
REQ-036 Reserved opcodes: reserved cmd_op values are accepted and ignored (1 cycle in IDLE, no side effects).
REQ-037 Held outputs: pc_out, flags_out and reg_wdata hold their last captured value between strobes.

Reset
REQ-038 Reset response: reset=0 asynchronously forces IDLE, SP=SP_INIT, all strobes, errors and the mem/reg/pc/flags data outputs to 0, and discards any in-flight command.
REQ-039 Reset mid-operation: a reset asserted during WR_HI, WR_LO, RD_1, RD_2 or RD_DONE produces no further write and no result strobe after release.
REQ-040 Ready after reset: cmd_ready=1 in the first cycle after reset release.

Verification
REQ-041 PUSH_PC, pc_in=32'h1234_5678 from reset: writes 16'h1234 to FFF, then 16'h5678 to FFE; SP=FFD.
REQ-042 POP_PC following REQ-041: reads FFE then FFF; pc_load pulses with pc_out=32'h1234_5678, 3 cycles after acceptance; SP=FFF.
REQ-043 PUSH_FLAGS 4'hA, then POP_FLAGS: flags_load pulses with flags_out=4'hA; SP returns to FFF.
REQ-044 POP_REG with SP=FFF: underflow pulses, no mem_re, SP stays FFF.
REQ-045 SP=800, PUSH_PC: overflow pulses, no write; the following PUSH_REG 16'hBEEF writes address 800 and sets SP=7FF.
REQ-046 Reset asserted during RD_2 of POP_PC: no pc_load pulse, SP=FFF after release, and cmd_ready=1 in the first cycle after release.
